// File: rtl/nfa_pkg.sv
// Shared definitions for the linear-chain NFA matcher.
// Holds the start-mode encodings, the field extractor for the packed per-state class table,
// and an elaboration-time legality check for the engine parameters.
package nfa_pkg;

  localparam int unsigned START_UNANCH = 0;  // a match may begin at any byte
  localparam int unsigned START_ANCH   = 1;  // a match must begin at the first byte after sod
  localparam int unsigned START_MULTI  = 2;  // first byte, or the byte after a newline class hit

  // Widest packed class table the helpers accept (64 states x 16-bit indices).
  localparam int unsigned MAX_SC_W = 1024;

  // Field i of the packed class table (field 0 in the least significant bits).
  function automatic int unsigned cls_idx(input logic [MAX_SC_W-1:0] state_class,
                                          input int unsigned i, input int unsigned cls_w);
    int unsigned idx;
    idx = 0;
    for (int unsigned b = 0; b < cls_w; b++) begin
      if (state_class[i*cls_w+b]) idx = idx | (32'd1 << b);
    end
    return idx;
  endfunction

  function automatic bit params_ok(input int unsigned n_states, input int unsigned n_classes,
                                   input int unsigned cls_w, input logic [63:0] skip,
                                   input logic [MAX_SC_W-1:0] state_class,
                                   input int unsigned nl_class, input int unsigned start_mode);
    bit ok;
    ok = 1'b1;
    if (n_states < 2 || n_states > 64) ok = 1'b0;
    if (n_states * cls_w > MAX_SC_W) ok = 1'b0;
    if (cls_w == 0 || cls_w > 16 || (32'd1 << cls_w) < n_classes) ok = 1'b0;
    if (skip[1:0] != 2'b00) ok = 1'b0;
    if (nl_class >= n_classes) ok = 1'b0;
    if (start_mode > START_MULTI) ok = 1'b0;
    if (ok) begin
      for (int unsigned i = 0; i < n_states; i++) begin
        if (cls_idx(state_class, i, cls_w) >= n_classes) ok = 1'b0;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/nfa_state_cell.sv
// One state of the NFA chain: a single flop that advances only on enabled bytes.
// Ports: clk, sod (async clear), en (clock enable), hit (this state's class hit for the byte),
//        pred (predecessor / start token), loop (self re-arm), skip (feed from two states back),
//        st (registered state).
module nfa_state_cell (
  input  logic clk,
  input  logic sod,
  input  logic en,
  input  logic hit,
  input  logic pred,
  input  logic loop,
  input  logic skip,
  output logic st
);

  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      st <= 1'b0;
    end else if (en) begin
      st <= hit & (pred | loop | skip);
    end
  end

endmodule

// File: rtl/nfa_chain_engine.sv
// Parametrised linear-chain NFA matcher: one instance matches one rule.
// Ports: clk; sod (async start-of-data clear); en (byte valid); cls_hit (class hits of the byte);
//        match (sticky); match_pulse (one cycle on the first match);
//        match_offset (1-based index of the byte that completed the first match);
//        byte_cnt (saturating count of enabled bytes since sod).
module nfa_chain_engine
  import nfa_pkg::*;
#(
  parameter int unsigned                  N_STATES    = 8,
  parameter int unsigned                  N_CLASSES   = 33,
  parameter int unsigned                  CLS_W       = 6,
  parameter logic [N_STATES*CLS_W-1:0]    STATE_CLASS = '0,
  parameter logic [N_STATES-1:0]          SELF_LOOP   = '0,
  parameter logic [N_STATES-1:0]          SKIP        = '0,
  parameter int unsigned                  START_MODE  = 0,
  parameter int unsigned                  NL_CLASS    = 0,
  parameter int unsigned                  OFS_W       = 16
) (
  input  logic                 clk,
  input  logic                 sod,
  input  logic                 en,
  input  logic [N_CLASSES-1:0] cls_hit,
  output logic                 match,
  output logic                 match_pulse,
  output logic [OFS_W-1:0]     match_offset,
  output logic [OFS_W-1:0]     byte_cnt
);

  localparam logic [MAX_SC_W-1:0] SC_EXT  = MAX_SC_W'(STATE_CLASS);
  localparam int unsigned         IDX_W   = (N_CLASSES > 1) ? $clog2(N_CLASSES) : 1;
  localparam logic [IDX_W-1:0]    NL_IDX  = IDX_W'(NL_CLASS);
  localparam logic [OFS_W-1:0]    CNT_MAX = '1;

  if (!params_ok(N_STATES, N_CLASSES, CLS_W, 64'(SKIP), SC_EXT, NL_CLASS, START_MODE))
  begin : g_param_err
    $error("nfa_chain_engine: illegal parameter set");
  end

  logic [N_STATES-1:0] st;
  logic                first_q;
  logic                nl_prev_q;
  logic                start_tok;
  logic                rise;

  // first_q marks the first enabled byte after sod; nl_prev_q remembers a newline on the last one.
  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      first_q   <= 1'b1;
      nl_prev_q <= 1'b0;
    end else if (en) begin
      first_q   <= 1'b0;
      nl_prev_q <= cls_hit[NL_IDX];
    end
  end

  always_comb begin
    start_tok = 1'b1;
    case (START_MODE)
      START_ANCH:  start_tok = first_q;
      START_MULTI: start_tok = first_q | nl_prev_q;
      default:     start_tok = 1'b1;
    endcase
  end

  for (genvar i = 0; i < N_STATES; i++) begin : g_state
    localparam logic [IDX_W-1:0] CIDX = IDX_W'(cls_idx(SC_EXT, i, CLS_W));
    logic pred;
    logic skip_in;

    if (i == 0) begin : g_head
      assign pred = start_tok;
    end else begin : g_body
      assign pred = st[i-1];
    end

    // Skip edge bypasses the optional state i-1.
    if (i >= 2) begin : g_skip
      assign skip_in = SKIP[i] & st[i-2];
    end else begin : g_noskip
      assign skip_in = 1'b0;
    end

    nfa_state_cell u_cell (
      .clk  (clk),
      .sod  (sod),
      .en   (en),
      .hit  (cls_hit[CIDX]),
      .pred (pred),
      .loop (SELF_LOOP[i] & st[i]),
      .skip (skip_in),
      .st   (st[i])
    );
  end

  // Only the first entry into the accepting state is reported and captured.
  assign rise = st[N_STATES-1] & ~match;

  always_ff @(posedge clk or posedge sod) begin
    if (sod) begin
      byte_cnt     <= '0;
      match        <= 1'b0;
      match_pulse  <= 1'b0;
      match_offset <= '0;
    end else begin
      if (en && byte_cnt != CNT_MAX) byte_cnt <= byte_cnt + 1'b1;
      match       <= match | st[N_STATES-1];
      match_pulse <= rise;
      if (rise) match_offset <= byte_cnt;
    end
  end

endmodule
